// File: rtl/command_dbuf.sv
// Command issue/complete FSM with sticky status, an RX FIFO (TL->AL) and a
// first-word-fall-through TX FIFO (AL->TL) that is released only while a command is in WAIT.
module command_dbuf #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 10,
  parameter int PORT_W = 4,
  parameter int TYPE_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [TYPE_W-1:0] al_cmd_type_in,
  input  logic [PORT_W-1:0] al_cmd_port_in,
  input  logic              al_cmd_val_in,
  input  logic              al_cmd_abort_in,
  output logic [1:0]        al_cmd_state_out,
  output logic              al_cmd_good_out,
  output logic              al_cmd_bad_out,
  output logic              al_cmd_reject_out,
  output logic [TYPE_W-1:0] cmd_type,
  output logic [PORT_W-1:0] cmd_port,
  output logic              cmd_val,
  input  logic              cmd_busy,
  input  logic              cmd_done_good,
  input  logic              cmd_done_bad,
  input  logic [DATA_W-1:0] tl_data_in,
  input  logic              tl_data_val_in,
  input  logic              tl_data_last_in,
  output logic              tl_data_busy_out,
  output logic [DATA_W-1:0] al_rdata_out,
  output logic              al_rdata_val_out,
  input  logic              al_rdata_strobe_in,
  output logic [ADDR_W:0]   rx_count_out,
  output logic              rx_overflow_out,
  output logic              rx_last_seen_out,
  input  logic [DATA_W-1:0] al_wdata_in,
  input  logic              al_wdata_last_in,
  input  logic              al_wdata_val_in,
  output logic [ADDR_W:0]   tx_count_out,
  output logic              tx_full_out,
  output logic              tx_overflow_out,
  output logic [DATA_W-1:0] tl_data_out,
  output logic              tl_data_last_out,
  output logic              tl_data_val_out,
  input  logic              tl_data_strobe_in
);

  localparam int DEPTH = 2**ADDR_W;
  localparam logic [ADDR_W:0] CNT_FULL = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] CNT_BUSY = (ADDR_W+1)'(DEPTH-1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t state;
  logic   issue;

  assign issue = al_cmd_val_in & ~al_cmd_abort_in & ((state == ST_IDLE) | (state == ST_DONE));
  assign al_cmd_state_out = state;
  assign cmd_val = (state == ST_ISSUE) & ~cmd_busy;

  always_ff @(posedge clk) begin
    if (rst) begin
      state             <= ST_IDLE;
      al_cmd_good_out   <= 1'b0;
      al_cmd_bad_out    <= 1'b0;
      al_cmd_reject_out <= 1'b0;
      cmd_type          <= '0;
      cmd_port          <= '0;
    end else begin
      al_cmd_reject_out <= al_cmd_val_in & ~al_cmd_abort_in &
                           ((state == ST_ISSUE) | (state == ST_WAIT));
      if (al_cmd_abort_in) begin
        state <= ST_IDLE;
      end else begin
        case (state)
          ST_IDLE, ST_DONE: begin
            if (al_cmd_val_in) begin
              state           <= ST_ISSUE;
              cmd_type        <= al_cmd_type_in;
              cmd_port        <= al_cmd_port_in;
              al_cmd_good_out <= 1'b0;
              al_cmd_bad_out  <= 1'b0;
            end
          end
          ST_ISSUE: begin
            if (!cmd_busy) state <= ST_WAIT;
          end
          ST_WAIT: begin
            if (cmd_done_bad) begin
              state          <= ST_DONE;
              al_cmd_bad_out <= 1'b1;
            end else if (cmd_done_good) begin
              state           <= ST_DONE;
              al_cmd_good_out <= 1'b1;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  // RX FIFO
  logic [DATA_W-1:0] rx_mem [DEPTH];
  logic [ADDR_W:0]   rx_wr_ptr, rx_rd_ptr;
  logic              rx_full, rx_empty, rx_we, rx_re;

  assign rx_count_out     = rx_wr_ptr - rx_rd_ptr;
  assign rx_full          = (rx_wr_ptr[ADDR_W] != rx_rd_ptr[ADDR_W]) &&
                            (rx_wr_ptr[ADDR_W-1:0] == rx_rd_ptr[ADDR_W-1:0]);
  assign rx_empty         = (rx_wr_ptr == rx_rd_ptr);
  assign rx_we            = tl_data_val_in & ~rx_full;
  assign rx_re            = al_rdata_strobe_in & ~rx_empty;
  assign tl_data_busy_out = (rx_count_out >= CNT_BUSY);

  always_ff @(posedge clk) begin
    if (rx_we) rx_mem[rx_wr_ptr[ADDR_W-1:0]] <= tl_data_in;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_wr_ptr        <= '0;
      rx_rd_ptr        <= '0;
      al_rdata_out     <= '0;
      al_rdata_val_out <= 1'b0;
      rx_overflow_out  <= 1'b0;
      rx_last_seen_out <= 1'b0;
    end else begin
      al_rdata_val_out <= rx_re;
      if (rx_we) rx_wr_ptr <= rx_wr_ptr + 1'b1;
      if (rx_re) begin
        rx_rd_ptr    <= rx_rd_ptr + 1'b1;
        al_rdata_out <= rx_mem[rx_rd_ptr[ADDR_W-1:0]];
      end
      if (issue) begin
        rx_overflow_out  <= 1'b0;
        rx_last_seen_out <= 1'b0;
      end
      if (tl_data_val_in && rx_full) rx_overflow_out  <= 1'b1;
      if (rx_we && tl_data_last_in)  rx_last_seen_out <= 1'b1;
    end
  end

  // TX FIFO: RAM plus a head register; capacity counts the head word
  logic [DATA_W:0]   tx_mem [DEPTH];
  logic [ADDR_W:0]   tx_wr_ptr, tx_rd_ptr, tx_mem_count;
  logic [DATA_W:0]   tx_head;
  logic              tx_head_valid, tx_mem_empty, tx_pop, tx_we;
  logic              tx_head_take, tx_bypass, tx_mem_we;

  assign tx_mem_count     = tx_wr_ptr - tx_rd_ptr;
  assign tx_mem_empty     = (tx_wr_ptr == tx_rd_ptr);
  assign tx_count_out     = tx_mem_count + {{ADDR_W{1'b0}}, tx_head_valid};
  assign tx_full_out      = (tx_count_out == CNT_FULL);
  assign tl_data_val_out  = tx_head_valid & (state == ST_WAIT);
  assign tl_data_out      = tx_head[DATA_W-1:0];
  assign tl_data_last_out = tx_head[DATA_W] & tl_data_val_out;
  assign tx_pop           = tl_data_strobe_in & tl_data_val_out;
  assign tx_we            = al_wdata_val_in & (~tx_full_out | tx_pop) & ~al_cmd_abort_in;
  assign tx_head_take     = ~tx_head_valid | tx_pop;
  // A word written while the RAM is empty and the head is free goes straight
  // to the head, so the RAM is never read and written at the same address.
  assign tx_bypass        = tx_head_take & tx_mem_empty & tx_we;
  assign tx_mem_we        = tx_we & ~tx_bypass;

  always_ff @(posedge clk) begin
    if (tx_mem_we) tx_mem[tx_wr_ptr[ADDR_W-1:0]] <= {al_wdata_last_in, al_wdata_in};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_wr_ptr     <= '0;
      tx_rd_ptr     <= '0;
      tx_head       <= '0;
      tx_head_valid <= 1'b0;
    end else if (al_cmd_abort_in) begin
      tx_rd_ptr     <= tx_wr_ptr;
      tx_head_valid <= 1'b0;
    end else begin
      if (tx_mem_we) tx_wr_ptr <= tx_wr_ptr + 1'b1;
      if (tx_head_take) begin
        if (!tx_mem_empty) begin
          tx_head       <= tx_mem[tx_rd_ptr[ADDR_W-1:0]];
          tx_rd_ptr     <= tx_rd_ptr + 1'b1;
          tx_head_valid <= 1'b1;
        end else if (tx_bypass) begin
          tx_head       <= {al_wdata_last_in, al_wdata_in};
          tx_head_valid <= 1'b1;
        end else begin
          tx_head_valid <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_overflow_out <= 1'b0;
    end else begin
      if (issue) tx_overflow_out <= 1'b0;
      if (al_wdata_val_in && !al_cmd_abort_in && !tx_we) tx_overflow_out <= 1'b1;
    end
  end

endmodule

// File: tb/tb_command_dbuf.sv
// Self-checking bench for command_dbuf (ADDR_W=4): directed command sequences plus
// a negedge scoreboard that tracks RX/TX FIFO contents, counts and read latency.
module tb_command_dbuf;
  localparam int DW = 32;
  localparam int AW = 4;
  localparam int PW = 4;
  localparam int TW = 3;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic [TW-1:0] al_cmd_type_in;
  logic [PW-1:0] al_cmd_port_in;
  logic          al_cmd_val_in, al_cmd_abort_in;
  logic [1:0]    al_cmd_state_out;
  logic          al_cmd_good_out, al_cmd_bad_out, al_cmd_reject_out;
  logic [TW-1:0] cmd_type;
  logic [PW-1:0] cmd_port;
  logic          cmd_val, cmd_busy, cmd_done_good, cmd_done_bad;
  logic [DW-1:0] tl_data_in;
  logic          tl_data_val_in, tl_data_last_in, tl_data_busy_out;
  logic [DW-1:0] al_rdata_out;
  logic          al_rdata_val_out, al_rdata_strobe_in;
  logic [AW:0]   rx_count_out;
  logic          rx_overflow_out, rx_last_seen_out;
  logic [DW-1:0] al_wdata_in;
  logic          al_wdata_last_in, al_wdata_val_in;
  logic [AW:0]   tx_count_out;
  logic          tx_full_out, tx_overflow_out;
  logic [DW-1:0] tl_data_out;
  logic          tl_data_last_out, tl_data_val_out, tl_data_strobe_in;

  command_dbuf #(.DATA_W(DW), .ADDR_W(AW), .PORT_W(PW), .TYPE_W(TW)) dut (
    .clk(clk), .rst(rst),
    .al_cmd_type_in(al_cmd_type_in), .al_cmd_port_in(al_cmd_port_in),
    .al_cmd_val_in(al_cmd_val_in), .al_cmd_abort_in(al_cmd_abort_in),
    .al_cmd_state_out(al_cmd_state_out), .al_cmd_good_out(al_cmd_good_out),
    .al_cmd_bad_out(al_cmd_bad_out), .al_cmd_reject_out(al_cmd_reject_out),
    .cmd_type(cmd_type), .cmd_port(cmd_port), .cmd_val(cmd_val),
    .cmd_busy(cmd_busy), .cmd_done_good(cmd_done_good), .cmd_done_bad(cmd_done_bad),
    .tl_data_in(tl_data_in), .tl_data_val_in(tl_data_val_in),
    .tl_data_last_in(tl_data_last_in), .tl_data_busy_out(tl_data_busy_out),
    .al_rdata_out(al_rdata_out), .al_rdata_val_out(al_rdata_val_out),
    .al_rdata_strobe_in(al_rdata_strobe_in), .rx_count_out(rx_count_out),
    .rx_overflow_out(rx_overflow_out), .rx_last_seen_out(rx_last_seen_out),
    .al_wdata_in(al_wdata_in), .al_wdata_last_in(al_wdata_last_in),
    .al_wdata_val_in(al_wdata_val_in), .tx_count_out(tx_count_out),
    .tx_full_out(tx_full_out), .tx_overflow_out(tx_overflow_out),
    .tl_data_out(tl_data_out), .tl_data_last_out(tl_data_last_out),
    .tl_data_val_out(tl_data_val_out), .tl_data_strobe_in(tl_data_strobe_in)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: queues hold words accepted by each FIFO, in order.
  logic [DW-1:0] rxq [$];
  logic [DW:0]   txq [$];
  logic          pend_rd = 1'b0;
  logic [DW-1:0] pend_data = '0;

  always @(negedge clk) begin
    logic rx_full_m, tx_full_m, pop;
    check("rx_val", al_rdata_val_out, pend_rd);
    if (pend_rd) check("rx_data", al_rdata_out, pend_data);
    check("rx_count", rx_count_out, rxq.size());
    check("tx_count", tx_count_out, txq.size());
    pop = tl_data_val_out && tl_data_strobe_in;
    if (pop) begin
      if (txq.size() == 0) check("tx_unexpected", 1, 0);
      else check("tx_word", {tl_data_last_out, tl_data_out}, txq[0]);
    end
    if (rst) begin
      rxq.delete();
      txq.delete();
      pend_rd = 1'b0;
    end else begin
      rx_full_m = (rxq.size() >= DEPTH);
      pend_rd = al_rdata_strobe_in && (rxq.size() > 0);
      if (pend_rd) pend_data = rxq.pop_front();
      if (tl_data_val_in && !rx_full_m) rxq.push_back(tl_data_in);
      tx_full_m = (txq.size() >= DEPTH);
      if (al_cmd_abort_in) begin
        txq.delete();
      end else begin
        if (pop && txq.size() > 0) void'(txq.pop_front());
        if (al_wdata_val_in && (!tx_full_m || pop)) txq.push_back({al_wdata_last_in, al_wdata_in});
      end
    end
  end

  initial begin
    int exp_cnt;
    rst = 1'b1;
    al_cmd_type_in = '0; al_cmd_port_in = '0; al_cmd_val_in = 1'b0; al_cmd_abort_in = 1'b0;
    cmd_busy = 1'b0; cmd_done_good = 1'b0; cmd_done_bad = 1'b0;
    tl_data_in = '0; tl_data_val_in = 1'b0; tl_data_last_in = 1'b0; al_rdata_strobe_in = 1'b0;
    al_wdata_in = '0; al_wdata_last_in = 1'b0; al_wdata_val_in = 1'b0; tl_data_strobe_in = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
    tick();
    check("rst_state", al_cmd_state_out, 0);
    check("rst_good", al_cmd_good_out, 0);
    check("rst_bad", al_cmd_bad_out, 0);
    check("rst_reject", al_cmd_reject_out, 0);
    check("rst_cmd_val", cmd_val, 0);
    check("rst_cmd_type", cmd_type, 0);
    check("rst_busy", tl_data_busy_out, 0);
    check("rst_rx_ovf", rx_overflow_out, 0);
    check("rst_tx_full", tx_full_out, 0);
    check("rst_tl_val", tl_data_val_out, 0);

    // Issue held off by cmd_busy for 4 cycles
    al_cmd_type_in = 3'd3; al_cmd_port_in = 4'd2; al_cmd_val_in = 1'b1; cmd_busy = 1'b1;
    tick();
    al_cmd_val_in = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) tick();
      check("iss_cmd_val0", cmd_val, 0);
      check("iss_state", al_cmd_state_out, 1);
      check("iss_type", cmd_type, 3);
      check("iss_port", cmd_port, 2);
    end
    cmd_busy = 1'b0;
    #1;
    check("iss_cmd_val1", cmd_val, 1);
    tick();
    check("wait_state", al_cmd_state_out, 2);
    check("wait_cmd_val", cmd_val, 0);
    check("wait_type", cmd_type, 3);
    check("wait_port", cmd_port, 2);

    // Reject, both-done, done ignored in DONE, re-issue, abort priority
    al_cmd_val_in = 1'b1;
    tick();
    al_cmd_val_in = 1'b0;
    check("reject_pulse", al_cmd_reject_out, 1);
    check("reject_state", al_cmd_state_out, 2);
    tick();
    check("reject_once", al_cmd_reject_out, 0);
    cmd_done_good = 1'b1; cmd_done_bad = 1'b1;
    tick();
    cmd_done_good = 1'b0; cmd_done_bad = 1'b0;
    check("both_state", al_cmd_state_out, 3);
    check("both_bad", al_cmd_bad_out, 1);
    check("both_good", al_cmd_good_out, 0);
    cmd_done_good = 1'b1;
    tick();
    cmd_done_good = 1'b0;
    check("done_ignored", al_cmd_good_out, 0);
    al_cmd_type_in = 3'd5; al_cmd_port_in = 4'd7; al_cmd_val_in = 1'b1; cmd_busy = 1'b1;
    tick();
    al_cmd_val_in = 1'b0;
    check("reiss_state", al_cmd_state_out, 1);
    check("reiss_bad", al_cmd_bad_out, 0);
    check("reiss_good", al_cmd_good_out, 0);
    check("reiss_type", cmd_type, 5);
    check("reiss_port", cmd_port, 7);
    al_cmd_val_in = 1'b1; al_cmd_abort_in = 1'b1;
    tick();
    al_cmd_val_in = 1'b0; al_cmd_abort_in = 1'b0; cmd_busy = 1'b0;
    check("abort_state", al_cmd_state_out, 0);
    check("abort_noreject", al_cmd_reject_out, 0);

    // RX overflow: 17 writes into 16 entries, the dropped one carries last
    for (int i = 0; i < 17; i++) begin
      tl_data_in = 32'h100 + i; tl_data_val_in = 1'b1; tl_data_last_in = (i == 16);
      tick();
      exp_cnt = (i + 1 > DEPTH) ? DEPTH : i + 1;
      check("rx_busy", tl_data_busy_out, exp_cnt >= DEPTH - 1);
    end
    tl_data_val_in = 1'b0; tl_data_last_in = 1'b0;
    check("rx_cnt16", rx_count_out, 16);
    check("rx_ovf", rx_overflow_out, 1);
    check("rx_last_dropped", rx_last_seen_out, 0);
    al_rdata_strobe_in = 1'b1;
    repeat (16) tick();
    al_rdata_strobe_in = 1'b0;
    tick();
    check("rx_drained", rx_count_out, 0);
    al_rdata_strobe_in = 1'b1;
    tick();
    al_rdata_strobe_in = 1'b0;
    check("rx_empty_strobe", al_rdata_val_out, 0);
    tick();
    check("rx_empty_cnt", rx_count_out, 0);

    // RX simultaneous read/write with pointer wrap
    for (int i = 0; i < 8; i++) begin
      tl_data_in = 32'h200 + i; tl_data_val_in = 1'b1;
      tick();
    end
    for (int i = 0; i < 40; i++) begin
      tl_data_in = 32'h300 + i; tl_data_last_in = (i == 20); al_rdata_strobe_in = 1'b1;
      tick();
      check("rx_rw_cnt", rx_count_out, 8);
    end
    tl_data_val_in = 1'b0; tl_data_last_in = 1'b0;
    repeat (8) tick();
    al_rdata_strobe_in = 1'b0;
    tick();
    check("rx_rw_drained", rx_count_out, 0);
    check("rx_last_seen", rx_last_seen_out, 1);

    // Reset in the middle of an RX burst
    for (int i = 0; i < 6; i++) begin
      tl_data_in = 32'h400 + i; tl_data_val_in = 1'b1;
      if (i == 3) rst = 1'b1;
      tick();
      if (i == 3) begin
        rst = 1'b0;
        check("mrst_rx_cnt", rx_count_out, 0);
        check("mrst_rx_ovf", rx_overflow_out, 0);
        check("mrst_rx_last", rx_last_seen_out, 0);
        check("mrst_tx_cnt", tx_count_out, 0);
        check("mrst_state", al_cmd_state_out, 0);
      end
    end
    tl_data_val_in = 1'b0;
    al_rdata_strobe_in = 1'b1;
    repeat (2) tick();
    al_rdata_strobe_in = 1'b0;
    tick();

    // TX: load in IDLE, release in WAIT
    for (int i = 0; i < 5; i++) begin
      al_wdata_in = 32'h500 + i; al_wdata_last_in = (i == 4); al_wdata_val_in = 1'b1;
      tick();
    end
    al_wdata_val_in = 1'b0; al_wdata_last_in = 1'b0;
    tick();
    check("tx_idle_val", tl_data_val_out, 0);
    check("tx_idle_cnt", tx_count_out, 5);
    al_cmd_type_in = 3'd1; al_cmd_port_in = 4'd1; al_cmd_val_in = 1'b1;
    tick();
    al_cmd_val_in = 1'b0;
    check("tx_iss_cmd_val", cmd_val, 1);
    tick();
    check("tx_wait_state", al_cmd_state_out, 2);
    tl_data_strobe_in = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check("tx_drain_val", tl_data_val_out, 1);
      check("tx_drain_last", tl_data_last_out, i == 4);
      check("tx_drain_cnt", tx_count_out, 5 - i);
      tick();
    end
    tl_data_strobe_in = 1'b0;
    check("tx_drained_cnt", tx_count_out, 0);
    check("tx_drained_val", tl_data_val_out, 0);
    al_wdata_in = 32'h600; al_wdata_val_in = 1'b1;
    tick();
    al_wdata_val_in = 1'b0;
    check("tx_empty_lat", tl_data_val_out, 1);
    for (int i = 1; i < 3; i++) begin
      al_wdata_in = 32'h600 + i; al_wdata_val_in = 1'b1;
      tick();
    end
    al_wdata_val_in = 1'b0;
    check("tx_pend3", tx_count_out, 3);
    al_cmd_abort_in = 1'b1;
    tick();
    al_cmd_abort_in = 1'b0;
    check("tx_abort_state", al_cmd_state_out, 0);
    check("tx_abort_cnt", tx_count_out, 0);
    check("tx_abort_val", tl_data_val_out, 0);

    // Good completion, then TX full with simultaneous write and pop
    al_cmd_val_in = 1'b1;
    tick();
    al_cmd_val_in = 1'b0;
    tick();
    cmd_done_good = 1'b1;
    tick();
    cmd_done_good = 1'b0;
    check("good_state", al_cmd_state_out, 3);
    check("good_good", al_cmd_good_out, 1);
    check("good_bad", al_cmd_bad_out, 0);
    al_cmd_val_in = 1'b1;
    tick();
    al_cmd_val_in = 1'b0;
    tick();
    for (int i = 0; i < 16; i++) begin
      al_wdata_in = 32'h700 + i; al_wdata_val_in = 1'b1;
      tick();
    end
    check("tx_full", tx_full_out, 1);
    check("tx_ovf_clear", tx_overflow_out, 0);
    al_wdata_in = 32'h7ff;
    tick();
    check("tx_ovf", tx_overflow_out, 1);
    check("tx_full_cnt", tx_count_out, 16);
    al_wdata_in = 32'h710; tl_data_strobe_in = 1'b1;
    tick();
    al_wdata_val_in = 1'b0;
    check("tx_wr_pop_full", tx_count_out, 16);
    repeat (16) tick();
    tl_data_strobe_in = 1'b0;
    check("tx_full_drained", tx_count_out, 0);
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/command_dbuf.md
Name: command_dbuf

Overview:
- Parametrised successor of the temporary SATA command layer.
- Sits between the application-layer register interface (al_*) and the transport layer (tl_*).
- Contains a command issue/complete state machine with sticky status.
- Contains a receive FIFO (TL→AL) with back-pressure and overflow detection, and a transmit FIFO (AL→TL) with per-word last marking, gated by command state.

Parameters:
DATA_W, 32, data word width for both FIFOs
ADDR_W, 10, FIFO address width; depth DEPTH = 2**ADDR_W words per FIFO
PORT_W, 4, port multiplier field width
TYPE_W, 3, command type field width

Ports:
clk  in  1  clock; everything is synchronous to it
rst  in  1  reset, synchronous, active-high
al_cmd_type_in  in  TYPE_W  command type, sampled on issue
al_cmd_port_in  in  PORT_W  command port, sampled on issue
al_cmd_val_in  in  1  issue strobe
al_cmd_abort_in  in  1  abort strobe
al_cmd_state_out  out  2  0 IDLE, 1 ISSUE, 2 WAIT, 3 DONE
al_cmd_good_out  out  1  sticky: last command done good
al_cmd_bad_out  out  1  sticky: last command done bad
al_cmd_reject_out  out  1  1-cycle pulse: issue ignored
cmd_type  out  TYPE_W  to TL
cmd_port  out  PORT_W  to TL
cmd_val  out  1  to TL
cmd_busy  in  1  from TL
cmd_done_good  in  1  from TL
cmd_done_bad  in  1  from TL
tl_data_in  in  DATA_W  RX word
tl_data_val_in  in  1  RX write
tl_data_last_in  in  1  RX last word
tl_data_busy_out  out  1  RX back-pressure
al_rdata_out  out  DATA_W  RX read data
al_rdata_val_out  out  1  al_rdata_out valid
al_rdata_strobe_in  in  1  RX read request
rx_count_out  out  ADDR_W+1  RX occupancy
rx_overflow_out  out  1  sticky RX drop
rx_last_seen_out  out  1  sticky: tl_data_last_in was written
al_wdata_in  in  DATA_W  TX word
al_wdata_last_in  in  1  TX last marker
al_wdata_val_in  in  1  TX write
tx_count_out  out  ADDR_W+1  TX occupancy
tx_full_out  out  1  TX full
tx_overflow_out  out  1  sticky TX drop
tl_data_out  out  DATA_W  TX head word
tl_data_last_out  out  1  TX head last marker
tl_data_val_out  out  1  TX head valid
tl_data_strobe_in  in  1  TX head consumed

Behaviour:
- Reset: all outputs 0; state IDLE; all pointers and sticky flags cleared. rst mid-operation drops FIFO contents and any in-flight command within one cycle.

Command FSM:
- IDLE or DONE + al_cmd_val_in → ISSUE:
  - Latch type and port.
  - Clear good, bad, rx_overflow, tx_overflow and rx_last_seen.
- ISSUE:
  - cmd_val = ~cmd_busy.
  - The cycle where cmd_val=1 is acceptance; the next state is WAIT.
  - cmd_type and cmd_port stay stable from ISSUE through DONE.
- WAIT:
  - cmd_done_bad → DONE with bad=1.
  - cmd_done_good → DONE with good=1.
  - Both asserted in the same cycle → bad=1 only.
  - Done inputs outside WAIT are ignored.
- al_cmd_val_in in ISSUE or WAIT is ignored and pulses al_cmd_reject_out for 1 cycle.
- al_cmd_abort_in in any state → IDLE.
  - Also flushes the TX FIFO (pointers equalised).
  - Good and bad are left unchanged.
  - Abort takes priority over a simultaneous al_cmd_val_in; no reject pulse in that case.

RX FIFO:
- Pointers are ADDR_W+1 bits. Full when MSBs differ and the rest are equal; empty when equal.
- Write when tl_data_val_in & ~full.
  - Write while full: word dropped, rx_overflow_out set.
  - A written word with tl_data_last_in=1 sets rx_last_seen_out.
- tl_data_busy_out = (rx_count_out >= DEPTH-1). This gives one word of slack for a 1-cycle TL reaction.
- Read when al_rdata_strobe_in & ~empty.
  - al_rdata_out and al_rdata_val_out are valid on the next cycle (1-cycle RAM latency).
  - Strobe while empty: ignored, pointer unchanged, al_rdata_val_out=0 next cycle.
- Simultaneous read and write leaves the count unchanged. Pointer wrap at DEPTH is natural binary wrap.

TX FIFO:
- Entries are DATA_W+1 wide: data plus the last marker.
- Write when al_wdata_val_in & ~full. Write while full: dropped, tx_overflow_out set.
- Output is first-word-fall-through from a head register.
  - tl_data_val_out = head_valid & (state==WAIT).
  - tl_data_last_out is the head marker, qualified by tl_data_val_out.
- Pop when tl_data_strobe_in & tl_data_val_out.
  - The next word appears the following cycle if one is present. Back-to-back strobes must sustain 1 word/cycle.
  - A strobe without tl_data_val_out is ignored.
- tx_count_out includes the head register word.
- Write into an empty FIFO: tl_data_val_out no earlier than 1 cycle later, and no later than 2 cycles later.
- Simultaneous write and pop at full frees one slot and the write is accepted.

Test Plan:
- Issue type=3, port=2 with cmd_busy=1 for 4 cycles → cmd_val=0 for 4 cycles, then 1 for one cycle; state ISSUE→WAIT; cmd_type=3, cmd_port=2 stable.
- WAIT, cmd_done_good and cmd_done_bad asserted together → state DONE, bad=1, good=0. A new issue in DONE clears both; a second issue while in WAIT → al_cmd_reject_out pulses exactly once.
- ADDR_W=4: write 17 RX words 0x100..0x110 without reads → tl_data_busy_out=1 once rx_count_out reaches 15; rx_count_out=16; 0x110 dropped; rx_overflow_out=1. 16 strobes return 0x100..0x10F in order, each 1 cycle after its strobe.
- RX: simultaneous read and write for 40 cycles with ADDR_W=4 → count constant, pointers wrap, data order preserved. Empty-strobe → al_rdata_val_out stays 0.
- TX: load 5 words, last marker on the 5th, in IDLE → tl_data_val_out=0. After issue and acceptance: continuous strobe drains 5 words in 5 cycles, tl_data_last_out=1 only on word 5, tx_count_out 5→0.
- Abort during WAIT with 3 TX words pending → state IDLE, tx_count_out=0, tl_data_val_out=0 next cycle. rst asserted mid-RX burst → all counts and flags 0 on the following cycle.
